// File: rtl/jsv_usb_irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jsv_usb_irq_pkg: shared constants and types for the USB side-band    |
// | interrupt controller.                             Revision: 1.0      |
// +----------------------------------------------------------------------+
package jsv_usb_irq_pkg;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_CAPTURE = 2'd2;
    localparam logic [1:0] ADDR_CONFIG  = 2'd3;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } dbnc_state_t;

    function automatic logic edge_match(input logic [1:0] mode,
                                        input logic       rise,
                                        input logic       fall);
        logic hit;
        hit = 1'b0;
        case (mode)
            EDGE_OFF:  hit = 1'b0;
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jsv_usb_irq_ctrl_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jsv_usb_irq_debounce: two-flop synchronizer, debounce FSM and        |
// | registered edge pulses for one pin.               Revision: 1.0      |
// +----------------------------------------------------------------------+
module jsv_usb_irq_debounce
    import jsv_usb_irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;
    dbnc_state_t      r_state;

    dbnc_state_t      w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_cnt    <= '0;
            r_state  <= ST_STABLE;
        end else begin
            r_meta  <= pin;
            r_sync  <= r_meta;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            if (w_accept) begin
                r_stable <= r_sync;
            end
        end
    end

    // Entering PENDING already counts as the first stable cycle, so the
    // >= compare also covers DEBOUNCE_CYCLES == 1 without wrapping.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_STABLE: begin
                w_cnt_nxt = '0;
                if (r_sync != r_stable) begin
                    w_state_nxt = ST_PENDING;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_PENDING: begin
                if (r_sync == r_stable) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= c_cnt_last) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_rise_nxt = w_accept &  r_sync;
        w_fall_nxt = w_accept & ~r_sync;
    end

    assign level = r_stable;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/jsv_usb_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jsv_usb_irq_ctrl: Avalon-MM slave capturing debounced MAX3421E       |
// | GPX/INT edges into a W1C register with a maskable irq. Rev: 1.0      |
// +----------------------------------------------------------------------+
module jsv_usb_irq_ctrl
    import jsv_usb_irq_pkg::*;
#(
    parameter int N_IN            = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      address,
    input  logic            read,
    input  logic            write,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    input  logic [N_IN-1:0] in_port,
    output logic            irq
);

    logic [N_IN-1:0]   w_level;
    logic [N_IN-1:0]   w_rise;
    logic [N_IN-1:0]   w_fall;
    logic [N_IN-1:0]   w_set;
    logic [N_IN-1:0]   w_clr;
    logic [N_IN-1:0]   w_capture_nxt;
    logic [31:0]       w_rdata;
    logic              w_unused;

    logic [N_IN-1:0]   r_mask;
    logic [N_IN-1:0]   r_capture;
    logic [2*N_IN-1:0] r_config;
    logic [31:0]       r_readdata;
    logic              r_irq;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_ch
            jsv_usb_irq_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .clk   (clk),
                .reset (reset),
                .pin   (in_port[gi]),
                .level (w_level[gi]),
                .rise  (w_rise[gi]),
                .fall  (w_fall[gi])
            );
        end
    endgenerate

    // Set is OR-ed after the clear so a simultaneous edge is never lost.
    always_comb begin
        w_set = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_set[i] = edge_match(r_config[2*i +: 2], w_rise[i], w_fall[i]);
        end
        w_clr         = (write && address == ADDR_CAPTURE) ? writedata[N_IN-1:0] : '0;
        w_capture_nxt = (r_capture & ~w_clr) | w_set;
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_STATUS:  w_rdata[N_IN-1:0]   = w_level;
            ADDR_MASK:    w_rdata[N_IN-1:0]   = r_mask;
            ADDR_CAPTURE: w_rdata[N_IN-1:0]   = r_capture;
            ADDR_CONFIG:  w_rdata[2*N_IN-1:0] = r_config;
            default:      w_rdata             = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask     <= '0;
            r_capture  <= '0;
            r_config   <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_capture  <= w_capture_nxt;
            r_readdata <= w_rdata;
            r_irq      <= |(r_capture & r_mask);
            if (write && address == ADDR_MASK) begin
                r_mask <= writedata[N_IN-1:0];
            end
            if (write && address == ADDR_CONFIG) begin
                r_config <= writedata[2*N_IN-1:0];
            end
        end
    end

    // Reads are side-effect free, so the strobe itself carries no information.
    assign w_unused = &{1'b0, read, writedata[31:2*N_IN]};

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_jsv_usb_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jsv_usb_irq_ctrl: directed bench for the USB side-band irq block. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_jsv_usb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  in_port;
    logic        irq;

    int checks = 0;
    int errors = 0;

    jsv_usb_irq_ctrl #(
        .N_IN            (2),
        .DEBOUNCE_CYCLES (16),
        .CNT_W           (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
        chk(tag, readdata, exp);
    endtask

    initial begin
        int irq_hi;
        reset     = 1'b1;
        address   = 2'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;
        in_port   = 2'b00;
        step(3);
        reset = 1'b0;

        // Reset state
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_readdata", readdata, 32'h0);
        rd_chk("rst_status", 2'd0, 32'h0);
        rd_chk("rst_mask", 2'd1, 32'h0);
        rd_chk("rst_capture", 2'd2, 32'h0);
        rd_chk("rst_config", 2'd3, 32'h0);

        // Unused bits and read-only STATUS
        wr(2'd1, 32'hFFFF_FFFF);
        rd_chk("mask_width", 2'd1, 32'h3);
        wr(2'd3, 32'hFFFF_FFFF);
        rd_chk("config_width", 2'd3, 32'hF);
        wr(2'd0, 32'hFFFF_FFFF);
        rd_chk("status_ro", 2'd0, 32'h0);
        wr(2'd1, 32'h0);
        wr(2'd3, 32'h0);

        // GPX rising edge: irq exactly 20 cycles after the pin edge
        wr(2'd3, 32'h1);
        wr(2'd1, 32'h1);
        in_port[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            chk($sformatf("gpx_lat_%0d", k), {31'b0, irq}, 32'(k == 20));
        end
        rd_chk("gpx_status", 2'd0, 32'h1);
        rd_chk("gpx_capture", 2'd2, 32'h1);
        wr(2'd2, 32'h1);
        step(1);
        chk("gpx_w1c_irq", {31'b0, irq}, 32'h0);
        rd_chk("gpx_w1c_capture", 2'd2, 32'h0);

        // INT glitch of 10 cycles is rejected
        wr(2'd3, 32'hC);
        wr(2'd1, 32'h2);
        in_port[1] = 1'b1;
        irq_hi = 0;
        for (int k = 0; k < 45; k++) begin
            if (k == 10) in_port[1] = 1'b0;
            step(1);
            if (irq) irq_hi++;
        end
        chk("glitch_irq_cycles", 32'(irq_hi), 32'h0);
        rd_chk("glitch_status", 2'd0, 32'h1);
        rd_chk("glitch_capture", 2'd2, 32'h0);

        // INT both-edge mode: rise, clear, then fall alone re-sets
        in_port[1] = 1'b1;
        step(40);
        rd_chk("both_rise_capture", 2'd2, 32'h2);
        rd_chk("both_rise_status", 2'd0, 32'h3);
        chk("both_rise_irq", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h2);
        step(1);
        chk("both_w1c_irq", {31'b0, irq}, 32'h0);
        rd_chk("both_w1c_capture", 2'd2, 32'h0);
        in_port[1] = 1'b0;
        step(40);
        rd_chk("both_fall_capture", 2'd2, 32'h2);
        rd_chk("both_fall_status", 2'd0, 32'h1);
        chk("both_fall_irq", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h2);
        step(2);
        chk("both_clean_irq", {31'b0, irq}, 32'h0);

        // W1C landing on the same cycle as the GPX edge pulse: set wins
        wr(2'd3, 32'hD);
        wr(2'd1, 32'h1);
        in_port[0] = 1'b0;
        step(40);
        rd_chk("race_fall_ignored", 2'd2, 32'h0);
        in_port[0] = 1'b1;
        step(18);
        wr(2'd2, 32'h1);
        step(1);
        chk("race_irq", {31'b0, irq}, 32'h1);
        rd_chk("race_capture", 2'd2, 32'h1);

        // Reset while GPX is pending with counter = 8
        wr(2'd2, 32'h1);
        step(2);
        in_port[0] = 1'b0;
        step(40);
        in_port[0] = 1'b1;
        step(10);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("midrst_irq", {31'b0, irq}, 32'h0);
        rd_chk("midrst_status", 2'd0, 32'h0);
        step(1);
        wr(2'd3, 32'h1);
        wr(2'd1, 32'h1);
        step(15);
        rd_chk("midrst_status_after", 2'd0, 32'h1);
        rd_chk("midrst_capture_after", 2'd2, 32'h1);
        chk("midrst_irq_after", {31'b0, irq}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
